// File: rtl/alu_core.sv
// alu_core: parameterised integer ALU with a combinational result and a
// registered zero/carry/overflow status register.
//
// Build option: define ALU_OVERFLOW_EN to register the signed-overflow flag
// for add/sub. Without it, flag_overflow is tied low. The internal overflow
// term is still computed because slt depends on it.
module alu_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [11:0]           alu_control,
  input  logic [DATA_WIDTH-1:0] alu_src1,
  input  logic [DATA_WIDTH-1:0] alu_src2,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  flag_overflow
);

  localparam int unsigned ShamtW = $clog2(DATA_WIDTH);
  localparam int unsigned HalfW  = DATA_WIDTH / 2;

  // Bit positions within the one-hot control word.
  localparam int unsigned OpAdd  = 11;
  localparam int unsigned OpSub  = 10;
  localparam int unsigned OpSlt  = 9;
  localparam int unsigned OpSltu = 8;
  localparam int unsigned OpAnd  = 7;
  localparam int unsigned OpNor  = 6;
  localparam int unsigned OpOr   = 5;
  localparam int unsigned OpXor  = 4;
  localparam int unsigned OpSll  = 3;
  localparam int unsigned OpSrl  = 2;
  localparam int unsigned OpSra  = 1;
  localparam int unsigned OpLui  = 0;

  logic                  op_add;
  logic                  op_sub;
  logic                  use_sub;
  logic [ShamtW-1:0]     shamt;
  logic [DATA_WIDTH-1:0] adder_b;
  logic [DATA_WIDTH:0]   adder_sum;
  logic [DATA_WIDTH-1:0] adder_res;
  logic                  adder_cout;
  logic                  adder_ovf;
  logic                  slt_bit;
  logic                  sltu_bit;

  logic [DATA_WIDTH-1:0] and_res;
  logic [DATA_WIDTH-1:0] nor_res;
  logic [DATA_WIDTH-1:0] or_res;
  logic [DATA_WIDTH-1:0] xor_res;
  logic [DATA_WIDTH-1:0] sll_res;
  logic [DATA_WIDTH-1:0] srl_res;
  logic [DATA_WIDTH-1:0] sra_res;
  logic [DATA_WIDTH-1:0] lui_res;
  logic [DATA_WIDTH-1:0] slt_res;
  logic [DATA_WIDTH-1:0] sltu_res;

  logic                  flag_zero_d;
  logic                  flag_zero_q;
  logic                  flag_carry_d;
  logic                  flag_carry_q;

  // Only the low shift-amount bits of src1 matter for shifts.
  logic                  unused_src1_hi;

  assign op_add  = alu_control[OpAdd];
  assign op_sub  = alu_control[OpSub];
  // Subtract and both compares share the adder in a + ~b + 1 mode.
  assign use_sub = alu_control[OpSub] | alu_control[OpSlt] | alu_control[OpSltu];
  assign shamt   = alu_src1[ShamtW-1:0];
  assign unused_src1_hi = ^alu_src1[DATA_WIDTH-1:ShamtW];

  // Shared W+1-bit adder; the extra bit is the carry-out.
  always_comb begin
    adder_b    = use_sub ? ~alu_src2 : alu_src2;
    adder_sum  = {1'b0, alu_src1} + {1'b0, adder_b} + {{DATA_WIDTH{1'b0}}, use_sub};
    adder_res  = adder_sum[DATA_WIDTH-1:0];
    adder_cout = adder_sum[DATA_WIDTH];
    // Overflow when both adder inputs agree in sign and the sum does not.
    adder_ovf  = (alu_src1[DATA_WIDTH-1] == adder_b[DATA_WIDTH-1]) &&
                 (adder_res[DATA_WIDTH-1] != alu_src1[DATA_WIDTH-1]);
    slt_bit    = adder_res[DATA_WIDTH-1] ^ adder_ovf;
    // No carry out of a + ~b + 1 means a borrow, i.e. a < b unsigned.
    sltu_bit   = ~adder_cout;
  end

  // Per-operation results for the logic, shift, compare and lui paths.
  always_comb begin
    and_res  = alu_src1 & alu_src2;
    nor_res  = ~(alu_src1 | alu_src2);
    or_res   = alu_src1 | alu_src2;
    xor_res  = alu_src1 ^ alu_src2;
    sll_res  = alu_src2 << shamt;
    srl_res  = alu_src2 >> shamt;
    sra_res  = $unsigned($signed(alu_src2) >>> shamt);
    lui_res  = {alu_src2[HalfW-1:0], {HalfW{1'b0}}};
    slt_res  = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
    sltu_res = {{(DATA_WIDTH-1){1'b0}}, sltu_bit};
  end

  // AND-OR result mux: no bit set gives 0, several bits OR their results.
  always_comb begin
    alu_result = ({DATA_WIDTH{alu_control[OpAdd]}}  & adder_res)
               | ({DATA_WIDTH{alu_control[OpSub]}}  & adder_res)
               | ({DATA_WIDTH{alu_control[OpSlt]}}  & slt_res)
               | ({DATA_WIDTH{alu_control[OpSltu]}} & sltu_res)
               | ({DATA_WIDTH{alu_control[OpAnd]}}  & and_res)
               | ({DATA_WIDTH{alu_control[OpNor]}}  & nor_res)
               | ({DATA_WIDTH{alu_control[OpOr]}}   & or_res)
               | ({DATA_WIDTH{alu_control[OpXor]}}  & xor_res)
               | ({DATA_WIDTH{alu_control[OpSll]}}  & sll_res)
               | ({DATA_WIDTH{alu_control[OpSrl]}}  & srl_res)
               | ({DATA_WIDTH{alu_control[OpSra]}}  & sra_res)
               | ({DATA_WIDTH{alu_control[OpLui]}}  & lui_res);
  end

  // Next-state for zero and carry flags; add takes priority over sub.
  always_comb begin
    flag_zero_d  = (alu_result == '0);
    flag_carry_d = 1'b0;
    if (op_add) begin
      flag_carry_d = adder_cout;
    end else if (op_sub) begin
      flag_carry_d = ~adder_cout;
    end
  end

  // Status register with synchronous active-high clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
    end else begin
      flag_zero_q  <= flag_zero_d;
      flag_carry_q <= flag_carry_d;
    end
  end

  assign flag_zero  = flag_zero_q;
  assign flag_carry = flag_carry_q;

`ifdef ALU_OVERFLOW_EN
  logic flag_overflow_d;
  logic flag_overflow_q;

  // Overflow is only meaningful for add and sub; other operations clear it.
  always_comb begin
    flag_overflow_d = (op_add | op_sub) & adder_ovf;
  end

  // Overflow flag register, cleared with the other flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_overflow_q <= 1'b0;
    end else begin
      flag_overflow_q <= flag_overflow_d;
    end
  end

  assign flag_overflow = flag_overflow_q;
`else
  assign flag_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core at DATA_WIDTH = 8: directed vector table, hand-written
// flag/reset sequences and randomized one-hot operations against a model.
module tb_alu_core;

  localparam int W = 8;

`ifdef ALU_OVERFLOW_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  localparam logic [11:0] CAdd  = 12'h800;
  localparam logic [11:0] CSub  = 12'h400;
  localparam logic [11:0] CSlt  = 12'h200;
  localparam logic [11:0] CSltu = 12'h100;
  localparam logic [11:0] CAnd  = 12'h080;
  localparam logic [11:0] CNor  = 12'h040;
  localparam logic [11:0] COr   = 12'h020;
  localparam logic [11:0] CXor  = 12'h010;
  localparam logic [11:0] CSll  = 12'h008;
  localparam logic [11:0] CSrl  = 12'h004;
  localparam logic [11:0] CSra  = 12'h002;
  localparam logic [11:0] CLui  = 12'h001;

  logic         clk;
  logic         reset;
  logic [11:0]  alu_control;
  logic [W-1:0] alu_src1;
  logic [W-1:0] alu_src2;
  logic [W-1:0] alu_result;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_overflow;

  int tests_run;
  int tests_failed;

  alu_core #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_control  (alu_control),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_result   (alu_result),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .flag_overflow(flag_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]  ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from the operation definitions using plain integer math.
  function automatic void model(input logic [11:0] ctrl, input int a, input int b,
                                output int res, output int z, output int c,
                                output int o);
    int sa_s;
    int sb_s;
    int sh;
    sa_s = (a >= 128) ? a - 256 : a;
    sb_s = (b >= 128) ? b - 256 : b;
    sh   = a % W;
    res  = 0;
    if (ctrl[11]) res |= (a + b) & 255;
    if (ctrl[10]) res |= (a - b) & 255;
    if (ctrl[9])  res |= (sa_s < sb_s) ? 1 : 0;
    if (ctrl[8])  res |= (a < b) ? 1 : 0;
    if (ctrl[7])  res |= a & b;
    if (ctrl[6])  res |= ~(a | b) & 255;
    if (ctrl[5])  res |= a | b;
    if (ctrl[4])  res |= a ^ b;
    if (ctrl[3])  res |= (b << sh) & 255;
    if (ctrl[2])  res |= b >> sh;
    if (ctrl[1])  res |= (sb_s >>> sh) & 255;
    if (ctrl[0])  res |= (b & 15) << 4;
    z = (res == 0) ? 1 : 0;
    c = 0;
    o = 0;
    if (ctrl[11]) begin
      c = (a + b > 255) ? 1 : 0;
      o = (sa_s + sb_s > 127 || sa_s + sb_s < -128) ? 1 : 0;
    end else if (ctrl[10]) begin
      c = (a < b) ? 1 : 0;
      o = (sa_s - sb_s > 127 || sa_s - sb_s < -128) ? 1 : 0;
    end
    if (!OvfEn) o = 0;
  endfunction

  task automatic drive(input logic [11:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_control = ctrl;
    alu_src1    = a;
    alu_src2    = b;
  endtask

  // Clock the current inputs into the flag register and compare flags.
  task automatic clock_flags(input string name, input int z, input int c, input int o);
    @(posedge clk);
    #1;
    check({name, ".zero"}, int'(flag_zero), z);
    check({name, ".carry"}, int'(flag_carry), c);
    check({name, ".ovf"}, int'(flag_overflow), o);
  endtask

  vec_t vecs[$];

  initial begin
    int r, z, c, o;
    logic [11:0] ctrl;
    tests_run    = 0;
    tests_failed = 0;

    vecs.push_back('{CAdd,  8'h7F, 8'h01, 8'h80});
    vecs.push_back('{CSub,  8'h05, 8'h07, 8'hFE});
    vecs.push_back('{CAdd,  8'hFF, 8'h01, 8'h00});
    vecs.push_back('{CSlt,  8'h80, 8'h01, 8'h01});
    vecs.push_back('{CSltu, 8'h80, 8'h01, 8'h00});
    vecs.push_back('{CSlt,  8'h33, 8'h33, 8'h00});
    vecs.push_back('{CSltu, 8'h33, 8'h33, 8'h00});
    vecs.push_back('{CSra,  8'h03, 8'h80, 8'hF0});
    vecs.push_back('{CSrl,  8'h03, 8'h80, 8'h10});
    vecs.push_back('{CSll,  8'h0B, 8'h80, 8'h00});
    vecs.push_back('{CAnd,  8'h0F, 8'hF0, 8'h00});
    vecs.push_back('{COr,   8'h0F, 8'hF0, 8'hFF});
    vecs.push_back('{CXor,  8'h0F, 8'hF0, 8'hFF});
    vecs.push_back('{CNor,  8'h0F, 8'hF0, 8'h00});
    vecs.push_back('{CLui,  8'h00, 8'hA5, 8'h50});
    vecs.push_back('{12'h000, 8'h12, 8'h34, 8'h00});
    vecs.push_back('{CAdd | CXor, 8'h01, 8'h02, 8'h03});
    vecs.push_back('{CSll,  8'hF9, 8'h03, 8'h06});

    // Reset state.
    reset = 1'b1;
    drive(12'h000, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.zero", int'(flag_zero), 0);
    check("reset.carry", int'(flag_carry), 0);
    check("reset.ovf", int'(flag_overflow), 0);
    reset = 1'b0;

    // Directed vectors: combinational result, then flags one edge later.
    foreach (vecs[i]) begin
      drive(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      #1;
      check($sformatf("vec%0d.result", i), int'(alu_result), int'(vecs[i].exp));
      model(vecs[i].ctrl, int'(vecs[i].a), int'(vecs[i].b), r, z, c, o);
      clock_flags($sformatf("vec%0d", i), z, c, o);
    end

    // Flag sequences from the directed plan.
    drive(CAdd, 8'h7F, 8'h01);
    clock_flags("seq_add_ovf", 0, 0, OvfEn ? 1 : 0);
    drive(CSub, 8'h05, 8'h07);
    clock_flags("seq_sub_borrow", 0, 1, 0);
    drive(CAdd, 8'hFF, 8'h01);
    clock_flags("seq_add_wrap", 1, 1, 0);

    // Mid-stream reset: flags clear, result stays combinational.
    reset = 1'b1;
    drive(CAdd, 8'h7F, 8'h01);
    #1;
    check("rst.result_add", int'(alu_result), 8'h80);
    clock_flags("rst_held", 0, 0, 0);
    drive(CSub, 8'h05, 8'h07);
    #1;
    check("rst.result_sub", int'(alu_result), 8'hFE);
    reset = 1'b0;
    drive(CAdd, 8'hFF, 8'h01);
    clock_flags("rst_release", 1, 1, 0);

    // Randomized one-hot operations (index 12 selects no operation).
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op   = $urandom_range(0, 12);
      ctrl = (op == 12) ? 12'h000 : (12'h001 << op);
      a    = W'($urandom);
      b    = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      drive(ctrl, a, b);
      model(ctrl, int'(a), int'(b), r, z, c, o);
      #1;
      check($sformatf("rand%0d.result ctrl=%03h a=%02h b=%02h", n, ctrl, a, b),
            int'(alu_result), r);
      clock_flags($sformatf("rand%0d", n), z, c, o);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Parameterised integer ALU for the CPU datapath. Operation is selected by a 12-bit one-hot control word.
- Result is combinational: it is valid in the same cycle the operands and control are applied, with no clock edge needed.
- A small clocked status register captures zero, carry and overflow flags of the current result for downstream branch/exception logic.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits. Must be even and >= 4; the bench uses 8.

Ports:
- clk  input  1  single system clock; flag register samples on its rising edge.
- reset  input  1  synchronous, active-high reset; clears flag register.
- alu_control  input  12  one-hot operation select.
- alu_src1  input  DATA_WIDTH  operand A; also the shift amount for shifts.
- alu_src2  input  DATA_WIDTH  operand B; the shifted value for shifts; the source for lui.
- alu_result  output  DATA_WIDTH  combinational result.
- flag_zero  output  1  registered: alu_result == 0.
- flag_carry  output  1  registered: add carry-out / sub borrow.
- flag_overflow  output  1  registered: signed overflow of add/sub.

Behaviour:
- Control bit map (each bit selects one operation; "src1", "src2" are the input operands):
  - [11] add: src1 + src2 (mod 2^W).
  - [10] sub: src1 - src2.
  - [9] slt: 1 if src1 < src2 signed, else 0 (zero-extended to W).
  - [8] sltu: 1 if src1 < src2 unsigned, else 0.
  - [7] and.
  - [6] nor.
  - [5] or.
  - [4] xor.
  - [3] sll: src2 << sa.
  - [2] srl: src2 >> sa, zero fill.
  - [1] sra: src2 >>> sa, sign fill.
  - [0] lui: {src2[W/2-1:0], W/2 zeros}.
- Shift amount sa = src1[clog2(W)-1:0]; the upper bits of src1 are ignored.
- add, sub, slt and sltu share one W+1-bit adder:
  - sub and compares use src1 + ~src2 + 1.
  - slt = sign of the difference XOR signed overflow.
  - sltu = NOT carry-out of the subtraction.
- Result mux is an AND-OR of the per-operation results gated by their control bits.
  - alu_control = 0 gives result 0.
  - Several bits set gives the bitwise OR of the selected results (defined; not a legal use).
- alu_result has no reset dependency: it is purely combinational, including while reset is high.
- Flag register, at each rising clk:
  - reset = 1: all flags cleared to 0.
  - Otherwise:
    - flag_zero <= (alu_result == 0).
    - flag_carry <= add ? carry-out : sub ? borrow (src1 < src2 unsigned) : 0.
    - flag_overflow per Optional Feature.
- Reset value of all flags is 0. Flag latency is 1 cycle after inputs settle.

Optional Feature:
- ALU_OVERFLOW_EN defined:
  - add: flag_overflow <= (sign src1 == sign src2) && (sign result != sign src1).
  - sub: flag_overflow <= (sign src1 != sign src2) && (sign result != sign src1).
  - All other operations: 0.
- ALU_OVERFLOW_EN undefined: flag_overflow is tied to 0 and the overflow logic is removed. Overflow is still computed internally for slt, and slt results are unchanged.

Test Plan:
- W=8, add 0x7F + 0x01 -> alu_result 0x80 same cycle; after next clk flag_overflow=1 (0 without ALU_OVERFLOW_EN), flag_carry=0, flag_zero=0.
- W=8, sub 0x05 - 0x07 -> 0xFE; next clk flag_carry=1. Then add 0xFF + 0x01 -> 0x00; next clk flag_zero=1, flag_carry=1.
- W=8, src1=0x80, src2=0x01: slt -> 0x01, sltu -> 0x00. Equal operands 0x33/0x33 -> 0x00 for both.
- W=8, src2=0x80: src1=0x03 sra -> 0xF0, srl -> 0x10; src1=0x0B sll (sa=3) -> 0x00.
- W=8 logic and lui:
  - 0x0F,0xF0: and -> 0x00, or -> 0xFF, xor -> 0xFF, nor -> 0x00.
  - lui src2=0xA5 -> 0x50.
  - alu_control=0 -> 0x00.
- Assert reset for one clk mid-stream with nonzero flags -> all flags 0 after that edge, while alu_result still tracks inputs combinationally. Deassert -> flags resume the next cycle.
